// File: rtl/smem_pkg.sv
// Shared encodings for the seed-extension pipeline stages.
// Status codes, FSM states and beat classification.
package smem_pkg;

  localparam logic [5:0] BCK_INI = 6'b00_1000;
  localparam logic [5:0] BCK_RUN = 6'b01_0000;
  localparam logic [5:0] BUBBLE  = 6'b00_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } bck_state_e;

  typedef enum logic [1:0] {
    BT_BUB = 2'd0,
    BT_INI = 2'd1,
    BT_RUN = 2'd2
  } beat_e;

  function automatic beat_e beat_kind(input logic [5:0] s);
    beat_e k;
    case (s)
      BCK_INI: k = BT_INI;
      BCK_RUN: k = BT_RUN;
      default: k = BT_BUB;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/bck_decide.sv
// Per-beat decision logic for the backward extension stage:
// break detection and mem/curr store qualification.
module bck_decide #(
  parameter int ADDR_W  = 7,
  parameter int INTV_W  = 64,
  parameter int AMBIG_C = 4
) (
  input  logic              boundary_i,
  input  logic [ADDR_W-1:0] bck_i_i,
  input  logic [7:0]        base_i,
  input  logic [INTV_W-1:0] ok_x2_i,
  input  logic [INTV_W-1:0] min_intv_i,
  input  logic [ADDR_W:0]   new_size_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [ADDR_W-1:0] last_mem_info_i,
  input  logic [INTV_W-1:0] last_token_i,
  output logic              brk_o,
  output logic              cond_mem_o,
  output logic              cond_curr_o,
  output logic [ADDR_W-1:0] new_i_o
);

  logic size_zero;

  assign size_zero = new_size_i == '0;

  assign new_i_o = boundary_i ? '0 : bck_i_i + 1'b1;

  assign brk_o = (base_i >= 8'(AMBIG_C))
              || boundary_i
              || (ok_x2_i < min_intv_i);

  // Only the first break of an iteration may record a mem entry.
  assign cond_mem_o = brk_o && size_zero
                   && ((mem_addr_i == '0)
                    || (new_i_o < last_mem_info_i));

  assign cond_curr_o = !brk_o
                    && (size_zero || (ok_x2_i != last_token_i));

endmodule

// File: rtl/backward_ctrl_stage.sv
// Backward extension control stage: tracks one read,
// emits mem/curr store writes and next-stage context.
module backward_ctrl_stage
  import smem_pkg::*;
#(
  parameter int MAX_READ   = 128,
  parameter int ADDR_W     = $clog2(MAX_READ),
  parameter int INTV_W     = 64,
  parameter int READ_NUM_W = 9,
  parameter int MEM_DEPTH  = 128,
  parameter int AMBIG_C    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_status,
  input  logic [READ_NUM_W-1:0] in_read_num,
  input  logic [ADDR_W-1:0]     in_backward_x,
  input  logic [ADDR_W-1:0]     in_fwd_size,
  input  logic [INTV_W-1:0]     in_min_intv,
  input  logic [7:0]            in_base,
  input  logic [INTV_W-1:0]     in_ok_x0,
  input  logic [INTV_W-1:0]     in_ok_x1,
  input  logic [INTV_W-1:0]     in_ok_x2,
  input  logic [INTV_W-1:0]     in_p_x0,
  input  logic [INTV_W-1:0]     in_p_x1,
  input  logic [INTV_W-1:0]     in_p_x2,
  input  logic [INTV_W-1:0]     in_p_info,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [READ_NUM_W-1:0] out_read_num,
  output logic [5:0]            out_status,
  output logic [ADDR_W-1:0]     out_backward_i,
  output logic [ADDR_W:0]       out_new_size,
  output logic                  out_last_one,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [INTV_W-1:0]     mem_x0,
  output logic [INTV_W-1:0]     mem_x1,
  output logic [INTV_W-1:0]     mem_x2,
  output logic [INTV_W-1:0]     mem_info,
  output logic                  curr_we,
  output logic [ADDR_W-1:0]     curr_addr,
  output logic [INTV_W-1:0]     curr_x0,
  output logic [INTV_W-1:0]     curr_x1,
  output logic [INTV_W-1:0]     curr_x2,
  output logic [INTV_W-1:0]     curr_info,
  output logic                  err_overflow
);

  localparam logic [ADDR_W-1:0] MEM_TOP = ADDR_W'(MEM_DEPTH - 1);

  bck_state_e state_q, state_d;
  beat_e kind;

  logic acc, ini_beat, run_beat;
  logic last_tok, last_one;
  logic brk, cond_mem, cond_curr;
  logic [ADDR_W-1:0] new_i;

  logic [ADDR_W-1:0] bi_q, bi_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic [ADDR_W-1:0] lmi_q, lmi_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [ADDR_W-1:0] fsz_q, fsz_d;
  logic [ADDR_W:0]   ns_q, ns_d;
  logic [INTV_W-1:0] ltok_q, ltok_d;
  logic bnd_q, bnd_d;
  logic err_d, mwe_d, cwe_d;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign kind     = beat_kind(in_status);
  assign ini_beat = acc && kind == BT_INI;
  assign run_beat = acc && kind == BT_RUN
                 && state_q == ST_RUN;
  assign last_tok = j_q == fsz_q - 1'b1;
  assign last_one = ns_q == '0 && cond_curr && last_tok;

  bck_decide #(
    .ADDR_W (ADDR_W),
    .INTV_W (INTV_W),
    .AMBIG_C(AMBIG_C)
  ) u_decide (
    .boundary_i     (bnd_q),
    .bck_i_i        (bi_q),
    .base_i         (in_base),
    .ok_x2_i        (in_ok_x2),
    .min_intv_i     (in_min_intv),
    .new_size_i     (ns_q),
    .mem_addr_i     (maddr_q),
    .last_mem_info_i(lmi_q),
    .last_token_i   (ltok_q),
    .brk_o          (brk),
    .cond_mem_o     (cond_mem),
    .cond_curr_o    (cond_curr),
    .new_i_o        (new_i)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      ini_beat:             state_d = ST_RUN;
      run_beat && last_one: state_d = ST_IDLE;
      default: ;
    endcase
  end

  always_comb begin
    bi_d    = bi_q;
    bnd_d   = bnd_q;
    ns_d    = ns_q;
    maddr_d = maddr_q;
    caddr_d = caddr_q;
    ltok_d  = ltok_q;
    lmi_d   = lmi_q;
    j_d     = j_q;
    fsz_d   = fsz_q;
    err_d   = err_overflow;
    mwe_d   = 1'b0;
    cwe_d   = 1'b0;
    unique case (1'b1)
      ini_beat: begin
        bnd_d   = in_backward_x == '0;
        bi_d    = bnd_d ? '0 : in_backward_x - 1'b1;
        ns_d    = '0;
        maddr_d = '0;
        caddr_d = in_fwd_size - 1'b1;
        ltok_d  = '0;
        lmi_d   = '0;
        j_d     = '0;
        fsz_d   = in_fwd_size;
      end
      run_beat: begin
        j_d = last_tok ? '0 : j_q + 1'b1;
        if (cond_mem) begin
          lmi_d = new_i;
          if (maddr_q == MEM_TOP) begin
            err_d = 1'b1;
          end else begin
            mwe_d   = 1'b1;
            maddr_d = maddr_q + 1'b1;
          end
        end
        // Overflow keeps bookkeeping but drops the store write.
        if (cond_curr) begin
          ltok_d = in_ok_x2;
          ns_d   = ns_q + 1'b1;
          if (caddr_q == '0) begin
            err_d = 1'b1;
          end else begin
            cwe_d   = 1'b1;
            caddr_d = caddr_q - 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bi_q         <= '0;
      bnd_q        <= 1'b0;
      ns_q         <= '0;
      maddr_q      <= '0;
      caddr_q      <= '0;
      ltok_q       <= '0;
      lmi_q        <= '0;
      j_q          <= '0;
      fsz_q        <= '0;
      err_overflow <= 1'b0;
    end else begin
      bi_q         <= bi_d;
      bnd_q        <= bnd_d;
      ns_q         <= ns_d;
      maddr_q      <= maddr_d;
      caddr_q      <= caddr_d;
      ltok_q       <= ltok_d;
      lmi_q        <= lmi_d;
      j_q          <= j_d;
      fsz_q        <= fsz_d;
      err_overflow <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid      <= 1'b0;
      out_read_num   <= '0;
      out_status     <= BUBBLE;
      out_backward_i <= '0;
      out_new_size   <= '0;
      out_last_one   <= 1'b0;
    end else if (acc) begin
      out_valid      <= 1'b1;
      out_read_num   <= in_read_num;
      out_status     <= ini_beat ? BCK_INI :
                        run_beat ? BCK_RUN : BUBBLE;
      out_backward_i <= bi_d;
      out_new_size   <= ns_d;
      out_last_one   <= run_beat && last_one;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_x0   <= '0;
      mem_x1   <= '0;
      mem_x2   <= '0;
      mem_info <= '0;
    end else begin
      mem_we <= mwe_d;
      if (mwe_d) begin
        mem_addr <= maddr_q;
        mem_x0   <= in_p_x0;
        mem_x1   <= in_p_x1;
        mem_x2   <= in_p_x2;
        mem_info <= (INTV_W'(new_i) << 32)
                  | INTV_W'(in_p_info[31:0]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      curr_we   <= 1'b0;
      curr_addr <= '0;
      curr_x0   <= '0;
      curr_x1   <= '0;
      curr_x2   <= '0;
      curr_info <= '0;
    end else begin
      curr_we <= cwe_d;
      if (cwe_d) begin
        curr_addr <= caddr_q;
        curr_x0   <= in_ok_x0;
        curr_x1   <= in_ok_x1;
        curr_x2   <= in_ok_x2;
        curr_info <= in_p_info;
      end
    end
  end

endmodule

// File: tb/tb_backward_ctrl_stage.sv
// Bench for backward_ctrl_stage: directed vector table,
// stall/reset sequences and a randomized model check.
module tb_backward_ctrl_stage;
  import smem_pkg::*;

  localparam int AW = 7;
  localparam int IW = 64;
  localparam int RW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_valid, in_ready;
  logic [5:0] in_status;
  logic [RW-1:0] in_read_num;
  logic [AW-1:0] in_backward_x, in_fwd_size;
  logic [IW-1:0] in_min_intv;
  logic [7:0] in_base;
  logic [IW-1:0] in_ok_x0, in_ok_x1, in_ok_x2;
  logic [IW-1:0] in_p_x0, in_p_x1, in_p_x2, in_p_info;
  logic out_valid, out_ready;
  logic [RW-1:0] out_read_num;
  logic [5:0] out_status;
  logic [AW-1:0] out_backward_i;
  logic [AW:0] out_new_size;
  logic out_last_one;
  logic mem_we, curr_we, err_overflow;
  logic [AW-1:0] mem_addr, curr_addr;
  logic [IW-1:0] mem_x0, mem_x1, mem_x2, mem_info;
  logic [IW-1:0] curr_x0, curr_x1, curr_x2, curr_info;

  backward_ctrl_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_status(in_status), .in_read_num(in_read_num),
    .in_backward_x(in_backward_x), .in_fwd_size(in_fwd_size),
    .in_min_intv(in_min_intv), .in_base(in_base),
    .in_ok_x0(in_ok_x0), .in_ok_x1(in_ok_x1), .in_ok_x2(in_ok_x2),
    .in_p_x0(in_p_x0), .in_p_x1(in_p_x1), .in_p_x2(in_p_x2),
    .in_p_info(in_p_info),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_read_num(out_read_num), .out_status(out_status),
    .out_backward_i(out_backward_i), .out_new_size(out_new_size),
    .out_last_one(out_last_one),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_x0(mem_x0), .mem_x1(mem_x1), .mem_x2(mem_x2),
    .mem_info(mem_info),
    .curr_we(curr_we), .curr_addr(curr_addr),
    .curr_x0(curr_x0), .curr_x1(curr_x1), .curr_x2(curr_x2),
    .curr_info(curr_info),
    .err_overflow(err_overflow)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] st,
                       input logic [6:0] bx, input logic [6:0] fs,
                       input logic [7:0] b, input logic [63:0] ok2,
                       input logic [63:0] mn, input logic [63:0] pi);
    in_valid      = v;
    in_status     = st;
    in_backward_x = bx;
    in_fwd_size   = fs;
    in_base       = b;
    in_ok_x2      = ok2;
    in_ok_x0      = ok2 ^ 64'h1111;
    in_ok_x1      = ok2 ^ 64'h2222;
    in_min_intv   = mn;
    in_p_info     = pi;
    in_p_x0       = pi + 64'd1;
    in_p_x1       = pi + 64'd2;
    in_p_x2       = pi + 64'd3;
    in_read_num   = in_read_num + 9'd1;
  endtask

  typedef struct {
    int st; int bx; int fs; int b; int ok2;
    int est; int ebi; int ens; int elo;
    int emwe; int ema; int eni;
    int ecwe; int eca; int eerr;
  } vec_t;

  vec_t tv[17];

  // Reference model state: store addresses derived from write counts.
  logic m_run, m_bnd, m_ov, m_err;
  logic [6:0] m_bi, m_lmi, m_fsz;
  int m_j, m_mcnt, m_ccnt;
  logic [7:0] m_ns;
  logic [63:0] m_ltok;
  logic [RW-1:0] e_rn;
  logic [5:0] e_st;
  logic [6:0] e_bi, e_maddr, e_caddr;
  logic [7:0] e_ns;
  logic e_lo, e_mwe, e_cwe;
  logic [63:0] e_minfo, e_cx2, e_cinfo;

  task automatic model_reset();
    m_run = 0; m_bnd = 0; m_ov = 0; m_err = 0;
    m_bi = 0; m_lmi = 0; m_fsz = 0; m_j = 0;
    m_mcnt = 0; m_ccnt = 0; m_ns = 0; m_ltok = 0;
    e_rn = 0; e_st = BUBBLE; e_bi = 0; e_ns = 0; e_lo = 0;
    e_mwe = 0; e_cwe = 0;
  endtask

  task automatic model_beat(input logic [5:0] st,
                            input logic [6:0] bx,
                            input logic [6:0] fs,
                            input logic [7:0] b,
                            input logic [63:0] ok2,
                            input logic [63:0] mn,
                            input logic [63:0] pi);
    logic [6:0] newi, ca;
    logic brk, lt;
    e_ov_set: begin
      m_ov = 1; e_rn = in_read_num; e_st = BUBBLE; e_lo = 0;
    end
    if (st == BCK_INI) begin
      m_run = 1; m_bnd = bx == 0;
      m_bi = (bx == 0) ? 7'd0 : bx - 7'd1;
      m_ns = 0; m_mcnt = 0; m_ccnt = 0; m_ltok = 0;
      m_lmi = 0; m_j = 0; m_fsz = fs; e_st = BCK_INI;
    end else if (st == BCK_RUN && m_run) begin
      newi = m_bnd ? 7'd0 : m_bi + 7'd1;
      brk = (b >= 8'd4) || m_bnd || (ok2 < mn);
      lt = m_j == int'(m_fsz) - 1;
      if (brk && m_ns == 0 && (m_mcnt == 0 || newi < m_lmi)) begin
        m_lmi = newi;
        if (m_mcnt == 127) m_err = 1;
        else begin
          e_mwe = 1; e_maddr = 7'(m_mcnt);
          e_minfo = (64'(newi) << 32) | {32'd0, pi[31:0]};
          m_mcnt++;
        end
      end
      if (!brk && (m_ns == 0 || ok2 != m_ltok)) begin
        e_lo = (m_ns == 0) && lt;
        m_ltok = ok2;
        ca = 7'(int'(m_fsz) - 1 - m_ccnt);
        if (ca == 0) m_err = 1;
        else begin
          e_cwe = 1; e_caddr = ca; e_cx2 = ok2; e_cinfo = pi;
          m_ccnt++;
        end
        m_ns = m_ns + 8'd1;
      end
      m_j = lt ? 0 : m_j + 1;
      if (e_lo) m_run = 0;
      e_st = BCK_RUN;
    end
    e_bi = m_bi; e_ns = m_ns;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 0; in_valid = 0;
    @(negedge clk);
    rst = 1;
    model_reset();
  endtask

  int cwe_cnt;

  initial begin
    rst = 0; out_ready = 1; in_read_num = 0;
    drive(0, BUBBLE, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_mem_we", 64'(mem_we), 0);
    chk("rst_curr_we", 64'(curr_we), 0);
    chk("rst_err", 64'(err_overflow), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    @(negedge clk);
    rst = 1;

    tv[0]  = '{8, 0,3,0,0,  8, 0,0,0, 0,0,0, 0,0, 0};
    tv[1]  = '{16,0,0,0,5,  16,0,0,0, 1,0,0, 0,0, 0};
    tv[2]  = '{16,0,0,0,5,  16,0,0,0, 0,0,0, 0,0, 0};
    tv[3]  = '{8, 5,3,0,0,  8, 4,0,0, 0,0,0, 0,0, 0};
    tv[4]  = '{16,0,0,0,10, 16,4,1,0, 0,0,0, 1,2, 0};
    tv[5]  = '{16,0,0,0,10, 16,4,1,0, 0,0,0, 0,0, 0};
    tv[6]  = '{16,0,0,0,7,  16,4,2,0, 0,0,0, 1,1, 0};
    tv[7]  = '{8, 5,3,0,0,  8, 4,0,0, 0,0,0, 0,0, 0};
    tv[8]  = '{16,0,0,4,10, 16,4,0,0, 1,0,5, 0,0, 0};
    tv[9]  = '{8, 3,2,0,0,  8, 2,0,0, 0,0,0, 0,0, 0};
    tv[10] = '{16,0,0,4,10, 16,2,0,0, 1,0,3, 0,0, 0};
    tv[11] = '{16,0,0,0,9,  16,2,1,1, 0,0,0, 1,1, 0};
    tv[12] = '{16,0,0,0,9,  0, 2,1,0, 0,0,0, 0,0, 0};
    tv[13] = '{1, 0,0,0,0,  0, 2,1,0, 0,0,0, 0,0, 0};
    tv[14] = '{8, 3,1,0,0,  8, 2,0,0, 0,0,0, 0,0, 0};
    tv[15] = '{16,0,0,0,9,  16,2,1,1, 0,0,0, 0,0, 1};
    tv[16] = '{1, 0,0,0,0,  0, 2,1,0, 0,0,0, 0,0, 1};

    for (int i = 0; i < 17; i++) begin
      logic [63:0] pi;
      pi = {32'hFEED0000, 32'(i * 7 + 3)};
      @(negedge clk);
      drive(1, 6'(tv[i].st), 7'(tv[i].bx), 7'(tv[i].fs),
            8'(tv[i].b), 64'(tv[i].ok2), 64'd1, pi);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 1);
      chk($sformatf("v%0d_status", i), 64'(out_status), 64'(tv[i].est));
      chk($sformatf("v%0d_bi", i), 64'(out_backward_i), 64'(tv[i].ebi));
      chk($sformatf("v%0d_ns", i), 64'(out_new_size), 64'(tv[i].ens));
      chk($sformatf("v%0d_last", i), 64'(out_last_one), 64'(tv[i].elo));
      chk($sformatf("v%0d_mwe", i), 64'(mem_we), 64'(tv[i].emwe));
      chk($sformatf("v%0d_cwe", i), 64'(curr_we), 64'(tv[i].ecwe));
      chk($sformatf("v%0d_err", i), 64'(err_overflow), 64'(tv[i].eerr));
      if (tv[i].emwe != 0) begin
        chk($sformatf("v%0d_maddr", i), 64'(mem_addr), 64'(tv[i].ema));
        chk($sformatf("v%0d_minfo", i), mem_info,
            (64'(tv[i].eni) << 32) | 64'(i * 7 + 3));
        chk($sformatf("v%0d_mx0", i), mem_x0, pi + 64'd1);
      end
      if (tv[i].ecwe != 0) begin
        chk($sformatf("v%0d_caddr", i), 64'(curr_addr), 64'(tv[i].eca));
        chk($sformatf("v%0d_cx2", i), curr_x2, 64'(tv[i].ok2));
        chk($sformatf("v%0d_cinfo", i), curr_info, pi);
      end
    end

    // Backpressure in the middle of a read.
    @(negedge clk);
    drive(1, BCK_INI, 10, 4, 0, 0, 1, 64'h100);
    @(negedge clk);
    drive(1, BCK_RUN, 0, 0, 0, 20, 1, 64'h200);
    @(posedge clk);
    #1;
    chk("stall_a_cwe", 64'(curr_we), 1);
    chk("stall_a_caddr", 64'(curr_addr), 3);
    @(negedge clk);
    out_ready = 0;
    drive(1, BCK_RUN, 0, 0, 0, 30, 1, 64'h300);
    cwe_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("stall_in_ready", 64'(in_ready), 0);
      chk("stall_cwe", 64'(curr_we), 0);
      chk("stall_ns", 64'(out_new_size), 1);
      chk("stall_status", 64'(out_status), 64'(BCK_RUN));
      chk("stall_cx2", curr_x2, 20);
    end
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1;
    cwe_cnt += int'(curr_we);
    chk("stall_b_caddr", 64'(curr_addr), 2);
    chk("stall_b_ns", 64'(out_new_size), 2);
    @(negedge clk);
    in_valid = 0;
    @(posedge clk);
    #1;
    cwe_cnt += int'(curr_we);
    chk("stall_b_once", 64'(cwe_cnt), 1);
    chk("stall_drain", 64'(out_valid), 0);

    // Asynchronous reset mid-read.
    @(negedge clk);
    drive(1, BCK_RUN, 0, 0, 0, 40, 1, 64'h400);
    @(negedge clk);
    in_valid = 0;
    #2;
    rst = 0;
    #1;
    chk("arst_valid", 64'(out_valid), 0);
    chk("arst_ns", 64'(out_new_size), 0);
    chk("arst_caddr", 64'(curr_addr), 0);
    chk("arst_err", 64'(err_overflow), 0);
    chk("arst_status", 64'(out_status), 0);
    chk("arst_cwe", 64'(curr_we), 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    drive(1, BCK_INI, 2, 2, 0, 0, 1, 64'h500);
    @(posedge clk);
    #1;
    chk("re_ini_bi", 64'(out_backward_i), 1);
    @(negedge clk);
    drive(1, BCK_RUN, 0, 0, 0, 5, 1, 64'h600);
    @(posedge clk);
    #1;
    chk("re_run_cwe", 64'(curr_we), 1);
    chk("re_run_caddr", 64'(curr_addr), 1);
    @(negedge clk);
    drive(1, BCK_RUN, 0, 0, 0, 5, 1, 64'h700);
    @(posedge clk);
    #1;
    chk("re_dup_cwe", 64'(curr_we), 0);
    chk("re_dup_ns", 64'(out_new_size), 1);
    chk("re_dup_last", 64'(out_last_one), 0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      logic v, acc;
      logic [5:0] st;
      int k;
      if (c % 400 == 0) pulse_reset();
      @(negedge clk);
      v = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      k = $urandom_range(0, 9);
      st = (k == 0) ? BCK_INI : (k < 8) ? BCK_RUN :
           (k == 8) ? 6'h01 : 6'h30;
      drive(v, st, 7'($urandom_range(0, 12)),
            7'($urandom_range(1, 6)), 8'($urandom_range(0, 5)),
            64'($urandom_range(0, 6)), 64'($urandom_range(0, 3)),
            {$urandom, $urandom});
      #1;
      chk("r_in_ready", 64'(in_ready), 64'(!m_ov || out_ready));
      acc = v && (!m_ov || out_ready);
      e_mwe = 0;
      e_cwe = 0;
      if (acc)
        model_beat(in_status, in_backward_x, in_fwd_size, in_base,
                   in_ok_x2, in_min_intv, in_p_info);
      else if (out_ready)
        m_ov = 0;
      @(posedge clk);
      #1;
      chk("r_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
        chk("r_status", 64'(out_status), 64'(e_st));
        chk("r_rn", 64'(out_read_num), 64'(e_rn));
        chk("r_bi", 64'(out_backward_i), 64'(e_bi));
        chk("r_ns", 64'(out_new_size), 64'(e_ns));
        chk("r_last", 64'(out_last_one), 64'(e_lo));
      end
      chk("r_mwe", 64'(mem_we), 64'(e_mwe));
      chk("r_cwe", 64'(curr_we), 64'(e_cwe));
      chk("r_err", 64'(err_overflow), 64'(m_err));
      if (e_mwe) begin
        chk("r_maddr", 64'(mem_addr), 64'(e_maddr));
        chk("r_minfo", mem_info, e_minfo);
      end
      if (e_cwe) begin
        chk("r_caddr", 64'(curr_addr), 64'(e_caddr));
        chk("r_cx2", curr_x2, e_cx2);
        chk("r_cinfo", curr_info, e_cinfo);
      end
    end

    @(negedge clk);
    in_valid = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
